// File: rtl/alu_seq_core.sv
// ============================================================================
// Module   : alu_seq_core
// Purpose  : Sequential arithmetic core for the UART calculator. Accepts one
//            operand pair and operator per valid/ready handshake and returns
//            a double-width result with status flags over a valid/ready
//            output handshake. Add/sub/div-by-zero finish in one cycle;
//            multiply (shift-add) and divide (restoring) iterate WIDTH times.
// Ports    : clk        - system clock, rising edge
//            rst        - asynchronous reset, active low
//            in_valid   - operand/operator present
//            in_ready   - core can accept (IDLE only)
//            a, b       - unsigned operands, WIDTH bits
//            op         - 00 add, 01 sub, 10 mul, 11 div
//            out_valid  - result/flags valid (DONE only)
//            out_ready  - consumer accepts result
//            result     - 2*WIDTH result word
//            carry      - add carry-out / sub borrow-out
//            div0       - divide-by-zero flag
//            busy       - high in CALC or DONE
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_seq_core #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [1:0]         op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               carry,
  output logic               div0,
  output logic               busy
);

  localparam int            CW     = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  localparam logic [1:0] C_OP_ADD = 2'b00;
  localparam logic [1:0] C_OP_SUB = 2'b01;
  localparam logic [1:0] C_OP_MUL = 2'b10;
  localparam logic [1:0] C_OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [1:0]         r_op;
  logic [WIDTH-1:0]   r_b;        // divisor
  logic [CW-1:0]      r_cnt;      // iteration counter
  logic [2*WIDTH-1:0] r_acc;      // multiply accumulator
  logic [2*WIDTH-1:0] r_mcand;    // multiplicand, shifted left each iteration
  logic [WIDTH-1:0]   r_mplier;   // multiplier, consumed LSB-first
  logic [WIDTH-1:0]   r_rem;      // partial remainder
  logic [WIDTH-1:0]   r_quo;      // dividend bits shift out, quotient bits shift in
  logic [2*WIDTH-1:0] r_result;
  logic               r_carry;
  logic               r_div0;

  logic               w_accept;
  logic               w_last;
  logic               w_to_calc;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_fast_result;
  logic               w_fast_carry;
  logic               w_fast_div0;
  logic [2*WIDTH-1:0] w_acc_next;
  logic [WIDTH:0]     w_rem_sh;
  logic               w_ge;
  logic [WIDTH-1:0]   w_rem_sub;
  logic [WIDTH-1:0]   w_rem_next;
  logic [WIDTH-1:0]   w_quo_next;

  assign w_accept  = in_valid && (r_state == S_IDLE);
  assign w_last    = (r_cnt == C_LAST);
  assign w_to_calc = (op == C_OP_MUL) || ((op == C_OP_DIV) && (b != '0));

  // Single-cycle results, computed straight from the inputs at accept time.
  assign w_sum  = {1'b0, a} + {1'b0, b};
  assign w_diff = {1'b0, a} - {1'b0, b};   // bit WIDTH is the borrow (a < b)

  always_comb begin
    w_fast_result = '0;
    w_fast_carry  = 1'b0;
    w_fast_div0   = 1'b0;
    case (op)
      C_OP_ADD: begin
        w_fast_result = {{(WIDTH-1){1'b0}}, w_sum};
        w_fast_carry  = w_sum[WIDTH];
      end
      C_OP_SUB: begin
        w_fast_result = {{WIDTH{1'b0}}, w_diff[WIDTH-1:0]};
        w_fast_carry  = w_diff[WIDTH];
      end
      C_OP_DIV: begin
        // Only reaches DONE directly when b == 0.
        w_fast_result = {a, {WIDTH{1'b1}}};
        w_fast_div0   = 1'b1;
      end
      default: ;
    endcase
  end

  // Shift-add multiply step.
  assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

  // Restoring divide step: bring in the next dividend bit, subtract if it fits.
  // The subtraction is only kept when w_ge, so the low WIDTH bits suffice.
  assign w_rem_sh   = {r_rem, r_quo[WIDTH-1]};
  assign w_ge       = (w_rem_sh >= {1'b0, r_b});
  assign w_rem_sub  = w_rem_sh[WIDTH-1:0] - r_b;
  assign w_rem_next = w_ge ? w_rem_sub : w_rem_sh[WIDTH-1:0];
  assign w_quo_next = {r_quo[WIDTH-2:0], w_ge};

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next-state and handshake outputs
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_next = w_to_calc ? S_CALC : S_DONE;
        end
      end
      S_CALC: begin
        busy = 1'b1;
        if (w_last) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Datapath; result/flags change only on the edge entering DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op     <= '0;
      r_b      <= '0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_div0   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op     <= op;
            r_b      <= b;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, a};
            r_mplier <= b;
            r_rem    <= '0;
            r_quo    <= a;
            if (!w_to_calc) begin
              r_result <= w_fast_result;
              r_carry  <= w_fast_carry;
              r_div0   <= w_fast_div0;
            end
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_op == C_OP_MUL) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
          end else begin
            r_rem <= w_rem_next;
            r_quo <= w_quo_next;
          end
          if (w_last) begin
            r_result <= (r_op == C_OP_MUL) ? w_acc_next : {w_rem_next, w_quo_next};
            r_carry  <= 1'b0;
            r_div0   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign result = r_result;
  assign carry  = r_carry;
  assign div0   = r_div0;

endmodule

`default_nettype wire

// File: tb/tb_alu_seq_core.sv
// ============================================================================
// Module   : tb_alu_seq_core
// Purpose  : Self-checking bench for alu_seq_core (WIDTH=8): directed vector
//            table plus hand-written backpressure and mid-operation reset
//            sequences.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_seq_core;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic [1:0]     op = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [2*W-1:0] result;
  logic           carry;
  logic           div0;
  logic           busy;

  int n_cmp = 0;
  int n_err = 0;

  alu_seq_core #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry),
    .div0      (div0),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  va;
    logic [7:0]  vb;
    logic [1:0]  vop;
    logic [15:0] exp_res;
    logic        exp_c;
    logic        exp_d0;
    int          exp_lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Issue one operation, scramble the inputs after the accept edge and wait
  // (bounded) for out_valid. Latency counts cycles from the accept edge.
  task automatic start_and_wait(input logic [7:0] ia, input logic [7:0] ib, input logic [1:0] iop,
                                output int lat, output logic rdy_low_ok);
    @(negedge clk);
    a = ia; b = ib; op = iop; in_valid = 1'b1;
    chk("in_ready_at_accept", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 8'($urandom); b = 8'($urandom); op = 2'($urandom);
    lat = 1;
    rdy_low_ok = 1'b1;
    while (out_valid !== 1'b1 && lat < 100) begin
      if (in_ready !== 1'b0 || busy !== 1'b1) rdy_low_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("in_ready_after_release", {31'd0, in_ready}, 32'd1);
    chk("out_valid_after_release", {31'd0, out_valid}, 32'd0);
  endtask

  vec_t vecs[16];

  initial begin
    int         lat;
    logic       ok;
    logic [15:0] held;

    vecs[0]  = '{8'd200, 8'd100, 2'b00, 16'h012C, 1'b1, 1'b0, 1};
    vecs[1]  = '{8'd5,   8'd9,   2'b01, 16'h00FC, 1'b1, 1'b0, 1};
    vecs[2]  = '{8'd9,   8'd5,   2'b01, 16'h0004, 1'b0, 1'b0, 1};
    vecs[3]  = '{8'd255, 8'd255, 2'b10, 16'hFE01, 1'b0, 1'b0, 9};
    vecs[4]  = '{8'd200, 8'd7,   2'b11, 16'h041C, 1'b0, 1'b0, 9};
    vecs[5]  = '{8'd42,  8'd0,   2'b11, 16'h2AFF, 1'b0, 1'b1, 1};
    vecs[6]  = '{8'd255, 8'd1,   2'b00, 16'h0100, 1'b1, 1'b0, 1};
    vecs[7]  = '{8'd3,   8'd4,   2'b00, 16'h0007, 1'b0, 1'b0, 1};
    vecs[8]  = '{8'd0,   8'd77,  2'b10, 16'h0000, 1'b0, 1'b0, 9};
    vecs[9]  = '{8'd13,  8'd11,  2'b10, 16'h008F, 1'b0, 1'b0, 9};
    vecs[10] = '{8'd7,   8'd200, 2'b11, 16'h0700, 1'b0, 1'b0, 9};
    vecs[11] = '{8'd255, 8'd1,   2'b11, 16'h00FF, 1'b0, 1'b0, 9};
    vecs[12] = '{8'd100, 8'd10,  2'b11, 16'h000A, 1'b0, 1'b0, 9};
    vecs[13] = '{8'd0,   8'd0,   2'b01, 16'h0000, 1'b0, 1'b0, 1};
    vecs[14] = '{8'd0,   8'd1,   2'b01, 16'h00FF, 1'b1, 1'b0, 1};
    vecs[15] = '{8'd2,   8'd128, 2'b10, 16'h0100, 1'b0, 1'b0, 9};

    // Reset state
    #2;
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result",    {16'd0, result},    32'd0);
    chk("rst_carry",     {31'd0, carry},     32'd0);
    chk("rst_div0",      {31'd0, div0},      32'd0);
    chk("rst_busy",      {31'd0, busy},      32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Directed vector table
    for (int i = 0; i < 16; i++) begin
      start_and_wait(vecs[i].va, vecs[i].vb, vecs[i].vop, lat, ok);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      chk($sformatf("v%0d_result", i), {16'd0, result}, {16'd0, vecs[i].exp_res});
      chk($sformatf("v%0d_carry", i), {31'd0, carry}, {31'd0, vecs[i].exp_c});
      chk($sformatf("v%0d_div0", i), {31'd0, div0}, {31'd0, vecs[i].exp_d0});
      chk($sformatf("v%0d_busy_done", i), {31'd0, busy}, 32'd1);
      if (vecs[i].exp_lat > 1)
        chk($sformatf("v%0d_in_ready_low_calc", i), {31'd0, ok}, 32'd1);
      release_result();
    end

    // Backpressure: mul 12*10, hold out_ready low 5 cycles with in_valid pulses
    start_and_wait(8'd12, 8'd10, 2'b10, lat, ok);
    chk("bp_latency", lat, 9);
    held = result;
    chk("bp_result", {16'd0, held}, 32'h0078);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = k[0];
      a = 8'd1; b = 8'd1; op = 2'b00;
      @(posedge clk); #1;
      chk($sformatf("bp_c%0d_result", k), {16'd0, result}, 32'h0078);
      chk($sformatf("bp_c%0d_in_ready", k), {31'd0, in_ready}, 32'd0);
      chk($sformatf("bp_c%0d_out_valid", k), {31'd0, out_valid}, 32'd1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    release_result();
    chk("bp_result_held_idle", {16'd0, result}, 32'h0078);
    @(posedge clk); #1;
    chk("bp_idle_no_accept", {31'd0, out_valid}, 32'd0);

    // Reset during div at iteration 4
    @(negedge clk);
    a = 8'd200; b = 8'd7; op = 2'b11; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    chk("mid_busy_before_rst", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_result",    {16'd0, result},    32'd0);
    chk("mid_rst_carry",     {31'd0, carry},     32'd0);
    chk("mid_rst_div0",      {31'd0, div0},      32'd0);
    chk("mid_rst_busy",      {31'd0, busy},      32'd0);
    @(negedge clk);
    rst = 1'b1;
    ok = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) ok = 1'b0;
    end
    chk("post_rst_no_stale_valid", {31'd0, ok}, 32'd1);
    start_and_wait(8'd1, 8'd1, 2'b00, lat, ok);
    chk("post_rst_add_latency", lat, 1);
    chk("post_rst_add_result", {16'd0, result}, 32'h0002);
    chk("post_rst_add_carry", {31'd0, carry}, 32'd0);
    release_result();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
